dcache_controller: RTL

//  Direct-mapped, write-back, write-allocate L1 data cache between CPU load/store

---
 rtl/dcache_controller.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 data cache with a 256-bit line-memory port.
// Optional DCACHE_STATS_EN adds saturating hit/miss/writeback counters.
module dcache_controller #(
    parameter int INDEX_W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o,
    output logic [31:0]  wb_cnt_o
`endif
);
    localparam int TAG_W = 27 - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, FILL} state_t;

    state_t               state_reg, state_next;
    logic [LINES-1:0]     valid_reg, dirty_reg;
    logic [TAG_W-1:0]     tag_reg [LINES];
    logic [255:0]         data_mem [LINES];
    logic [26:0]          miss_line_reg;
    logic [255:0]         fill_reg;

    logic                 mem_enable_reg, mem_enable_next;
    logic                 mem_write_reg, mem_write_next;
    logic [31:0]          mem_addr_reg, mem_addr_next;
    logic [255:0]         mem_data_reg, mem_data_next;

    logic [TAG_W-1:0]     cpu_tag;
    logic [INDEX_W-1:0]   cpu_idx;
    logic [2:0]           cpu_word;
    logic [TAG_W-1:0]     miss_tag;
    logic [INDEX_W-1:0]   miss_idx;
    logic                 hit, store_hit;
    logic                 unused_addr_bits;

    assign cpu_tag          = cpu_addr_i[31:5+INDEX_W];
    assign cpu_idx          = cpu_addr_i[5+INDEX_W-1:5];
    assign cpu_word         = cpu_addr_i[4:2];
    assign miss_tag         = miss_line_reg[26:INDEX_W];
    assign miss_idx         = miss_line_reg[INDEX_W-1:0];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign hit         = valid_reg[cpu_idx] & (tag_reg[cpu_idx] == cpu_tag);
    assign store_hit   = (state_reg == IDLE) & cpu_req_i & cpu_we_i & hit;
    assign cpu_stall_o = cpu_req_i & (~hit | (state_reg != IDLE));
    assign cpu_data_o  = data_mem[cpu_idx][{cpu_word, 5'd0} +: 32];

    assign mem_enable_o = mem_enable_reg;
    assign mem_write_o  = mem_write_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_data_o   = mem_data_reg;

    always_comb begin
        state_next      = state_reg;
        mem_enable_next = mem_enable_reg;
        mem_write_next  = mem_write_reg;
        mem_addr_next   = mem_addr_reg;
        mem_data_next   = mem_data_reg;
        case (state_reg)
            IDLE: begin
                mem_enable_next = 1'b0;
                mem_write_next  = 1'b0;
                if (cpu_req_i && !hit) begin
                    mem_enable_next = 1'b1;
                    if (valid_reg[cpu_idx] && dirty_reg[cpu_idx]) begin
                        state_next     = WRITEBACK;
                        mem_write_next = 1'b1;
                        mem_addr_next  = {tag_reg[cpu_idx], cpu_idx, 5'b0};
                        mem_data_next  = data_mem[cpu_idx];
                    end else begin
                        state_next    = ALLOCATE;
                        mem_addr_next = {cpu_tag, cpu_idx, 5'b0};
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_next      = ALLOCATE;
                    mem_enable_next = 1'b0;
                    mem_write_next  = 1'b0;
                end
            end
            ALLOCATE: begin
                // Enable is low for one cycle on entry from WRITEBACK, then the fill is requested.
                if (mem_enable_reg && mem_ack_i) begin
                    state_next      = FILL;
                    mem_enable_next = 1'b0;
                end else if (!mem_enable_reg) begin
                    mem_enable_next = 1'b1;
                    mem_write_next  = 1'b0;
                    mem_addr_next   = {miss_line_reg, 5'b0};
                end
            end
            FILL: begin
                state_next      = IDLE;
                mem_enable_next = 1'b0;
                mem_write_next  = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg      <= IDLE;
            valid_reg      <= '0;
            dirty_reg      <= '0;
            mem_enable_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            mem_enable_reg <= mem_enable_next;
            mem_write_reg  <= mem_write_next;
            mem_addr_reg   <= mem_addr_next;
            mem_data_reg   <= mem_data_next;
            if (state_reg == FILL) begin
                valid_reg[miss_idx] <= 1'b1;
                dirty_reg[miss_idx] <= 1'b0;
            end else if (store_hit) begin
                dirty_reg[cpu_idx] <= 1'b1;
            end
        end
    end

    // Miss line is latched so the fill completes even if the CPU drops its request.
    always_ff @(posedge clk_i) begin
        if (state_reg == IDLE && cpu_req_i && !hit)
            miss_line_reg <= cpu_addr_i[31:5];
        if (state_reg == ALLOCATE && mem_enable_reg && mem_ack_i)
            fill_reg <= mem_data_i;
        if (state_reg == FILL) begin
            tag_reg[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= fill_reg;
        end else if (store_hit) begin
            data_mem[cpu_idx][{cpu_word, 5'd0} +: 32] <= cpu_data_i;
        end
    end

`ifdef DCACHE_STATS_EN
    logic        after_fill_reg;
    logic [31:0] hit_cnt_reg, miss_cnt_reg, wb_cnt_reg;

    // The retiring cycle after a fill belongs to a miss and must not count as a hit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            after_fill_reg <= 1'b0;
            hit_cnt_reg    <= '0;
            miss_cnt_reg   <= '0;
            wb_cnt_reg     <= '0;
        end else begin
            after_fill_reg <= (state_reg == FILL);
            if (state_reg == IDLE && cpu_req_i && hit && !after_fill_reg && hit_cnt_reg != 32'hFFFF_FFFF)
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            if (state_reg == IDLE && state_next != IDLE && miss_cnt_reg != 32'hFFFF_FFFF)
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
            if (state_reg == IDLE && state_next == WRITEBACK && wb_cnt_reg != 32'hFFFF_FFFF)
                wb_cnt_reg <= wb_cnt_reg + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_reg;
    assign miss_cnt_o = miss_cnt_reg;
    assign wb_cnt_o   = wb_cnt_reg;
`endif

endmodule
